input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner.sv | 99 +++++++++
 tb/tb_input_conditioner.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Two-flop synchronizers for slide switches and buttons, plus per-button debounce with press/release pulses.
// Define SWITCH_SNAPSHOT_EN to latch switch data only after a debounced button2 press.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] switch1_raw,
  input  logic [2:0] button_raw,
  output logic [7:0] switch1,
  output logic [2:0] btn_level,
  output logic [2:0] btn_press,
  output logic [2:0] btn_release
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [7:0] sw_meta_q, sw_sync_q;
  logic [2:0] btn_meta_q, btn_sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
    end else begin
      sw_meta_q  <= switch1_raw;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= button_raw;
      btn_sync_q <= btn_meta_q;
    end
  end

  logic [2:0]      stable_q, stable_d;
  logic [2:0]      press_q, press_d;
  logic [2:0]      release_q, release_d;
  logic [CntW-1:0] cnt_q [3];
  logic [CntW-1:0] cnt_d [3];

  // Pulses are produced alongside the stable update so they line up with the new level.
  always_comb begin
    stable_d  = stable_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (btn_sync_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i]  = btn_sync_q[i];
          press_d[i]   = btn_sync_q[i];
          release_d[i] = ~btn_sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn_level   = stable_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

`ifdef SWITCH_SNAPSHOT_EN
  logic [7:0] switch1_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      switch1_q <= '0;
    end else if (press_q[1]) begin
      switch1_q <= sw_sync_q;
    end
  end

  assign switch1 = switch1_q;
`else
  assign switch1 = sw_sync_q;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DEBOUNCE_CYCLES=4: directed table, corner sequences, random vs model.
module tb_input_conditioner;

  localparam int unsigned D  = 4;
  localparam int          DI = 4;
`ifdef SWITCH_SNAPSHOT_EN
  localparam bit Snap = 1'b1;
`else
  localparam bit Snap = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] switch1_raw;
  logic [2:0] button_raw;
  logic [7:0] switch1;
  logic [2:0] btn_level, btn_press, btn_release;

  input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .switch1_raw(switch1_raw),
    .button_raw (button_raw),
    .switch1    (switch1),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: raw samples per edge since reset; a level flips once the D
  // synchronized samples ending one edge ago all disagree with it.
  logic [2:0] bhist[$];
  logic [7:0] shist[$];
  logic [2:0] m_level, m_press, m_release;
  logic [7:0] m_sw;

  function automatic bit window_all(input int i, input logic v);
    int n = bhist.size();
    for (int j = n - 2 - DI; j <= n - 3; j++) begin
      logic s;
      s = (j < 0) ? 1'b0 : bhist[j][i];
      if (s !== v) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [7:0] sw_back(input int k);
    int idx = shist.size() - k;
    return (idx < 0) ? 8'h00 : shist[idx];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      bhist.delete();
      shist.delete();
      m_level   <= '0;
      m_press   <= '0;
      m_release <= '0;
      m_sw      <= '0;
    end else begin
      bhist.push_back(button_raw);
      shist.push_back(switch1_raw);
      for (int i = 0; i < 3; i++) begin
        if (window_all(i, ~m_level[i])) begin
          m_level[i]   <= ~m_level[i];
          m_press[i]   <= ~m_level[i];
          m_release[i] <= m_level[i];
        end else begin
          m_press[i]   <= 1'b0;
          m_release[i] <= 1'b0;
        end
      end
      if (Snap) begin
        if (m_press[1]) m_sw <= sw_back(3);
      end else begin
        m_sw <= sw_back(2);
      end
    end
  end

  typedef struct packed {
    logic [2:0] btn;
    logic [7:0] sw;
    logic [2:0] lvl;
    logic [2:0] prs;
    logic [2:0] rel;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic [2:0] btn, input logic [2:0] lvl, input logic [2:0] prs,
                     input logic [2:0] rel);
    vec_t v;
    v.btn = btn;
    v.sw  = 8'(tbl.size() * 29 + 5);
    v.lvl = lvl;
    v.prs = prs;
    v.rel = rel;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    button_raw  = 3'b111;
    switch1_raw = 8'hff;
    step(3);
    chk("reset_level", {29'd0, btn_level}, 32'd0);
    chk("reset_press", {29'd0, btn_press}, 32'd0);
    chk("reset_release", {29'd0, btn_release}, 32'd0);
    chk("reset_switch", {24'd0, switch1}, 32'd0);
    button_raw  = 3'b000;
    switch1_raw = 8'h00;
    reset       = 1'b1;
  endtask

  initial begin
    logic [7:0] prev_sw;
    logic [2:0] acc;
    logic [7:0] sw_val;
    logic [2:0] b_val;

    // Single press of button1, a too-short glitch on button2, then release of button1.
    repeat (5) row(3'b001, 3'b000, 3'b000, 3'b000);
    row(3'b001, 3'b001, 3'b001, 3'b000);
    repeat (2) row(3'b001, 3'b001, 3'b000, 3'b000);
    repeat (3) row(3'b011, 3'b001, 3'b000, 3'b000);
    repeat (5) row(3'b001, 3'b001, 3'b000, 3'b000);
    repeat (5) row(3'b000, 3'b001, 3'b000, 3'b000);
    row(3'b000, 3'b000, 3'b000, 3'b001);
    row(3'b000, 3'b000, 3'b000, 3'b000);

    do_reset();
    prev_sw = 8'h00;
    for (int r = 0; r < tbl.size(); r++) begin
      button_raw  = tbl[r].btn;
      switch1_raw = tbl[r].sw;
      step(1);
      chk($sformatf("tbl%0d_level", r), {29'd0, btn_level}, {29'd0, tbl[r].lvl});
      chk($sformatf("tbl%0d_press", r), {29'd0, btn_press}, {29'd0, tbl[r].prs});
      chk($sformatf("tbl%0d_release", r), {29'd0, btn_release}, {29'd0, tbl[r].rel});
      chk($sformatf("tbl%0d_switch", r), {24'd0, switch1}, {24'd0, Snap ? 8'h00 : prev_sw});
      prev_sw = tbl[r].sw;
    end

    // Button1 toggling every two cycles never settles; final rise is accepted once.
    acc = '0;
    for (int c = 0; c < 12; c++) begin
      button_raw = {2'b00, (c % 4) < 2};
      step(1);
      acc |= btn_press | btn_level;
    end
    chk("toggle_no_press", {29'd0, acc}, 32'd0);
    button_raw = 3'b001;
    acc = '0;
    for (int c = 0; c < 5; c++) begin
      step(1);
      acc |= btn_press | btn_level;
    end
    chk("toggle_early", {29'd0, acc}, 32'd0);
    step(1);
    chk("toggle_press", {29'd0, btn_press}, 32'd1);
    chk("toggle_level", {29'd0, btn_level}, 32'd1);
    step(1);
    chk("toggle_press_once", {29'd0, btn_press}, 32'd0);

    // Simultaneous release of buttons 1 and 2.
    button_raw = 3'b011;
    step(8);
    chk("dual_level_high", {29'd0, btn_level}, 32'd3);
    chk("dual_quiet", {29'd0, btn_press | btn_release}, 32'd0);
    button_raw = 3'b000;
    acc = '0;
    for (int c = 0; c < 5; c++) begin
      step(1);
      acc |= btn_release;
    end
    chk("dual_early", {29'd0, acc}, 32'd0);
    step(1);
    chk("dual_release", {29'd0, btn_release}, 32'd3);
    chk("dual_no_press", {29'd0, btn_press}, 32'd0);
    step(1);
    chk("dual_release_once", {29'd0, btn_release}, 32'd0);
    chk("dual_level_low", {29'd0, btn_level}, 32'd0);

    // Switch snapshot on button2 press versus transparent switch path.
    switch1_raw = 8'haa;
    step(3);
    button_raw = 3'b010;
    step(6);
    chk("sw_btn2_press", {29'd0, btn_press}, 32'd2);
    step(1);
    chk("sw_after_press", {24'd0, switch1}, 32'haa);
    switch1_raw = 8'h62;
    step(1);
    chk("sw_one_edge", {24'd0, switch1}, 32'haa);
    step(1);
    chk("sw_two_edges", {24'd0, switch1}, {24'd0, Snap ? 8'haa : 8'h62});
    step(4);
    chk("sw_held", {24'd0, switch1}, {24'd0, Snap ? 8'haa : 8'h62});

    // Reset mid-count on button3 discards the count; held button re-presses after release.
    button_raw = 3'b100;
    step(4);
    chk("pre_reset_level", {29'd0, btn_level}, 32'd2);
    reset = 1'b0;
    #1;
    chk("midrst_level", {29'd0, btn_level}, 32'd0);
    chk("midrst_pulses", {29'd0, btn_press | btn_release}, 32'd0);
    chk("midrst_switch", {24'd0, switch1}, 32'd0);
    step(1);
    reset = 1'b1;
    acc = '0;
    for (int c = 0; c < 5; c++) begin
      step(1);
      acc |= btn_press | btn_release | btn_level;
    end
    chk("postrst_quiet", {29'd0, acc}, 32'd0);
    step(1);
    chk("postrst_press", {29'd0, btn_press}, 32'd4);
    chk("postrst_level", {29'd0, btn_level}, 32'd4);
    step(1);
    chk("postrst_press_once", {29'd0, btn_press}, 32'd0);

    // Random stimulus against the reference model.
    do_reset();
    b_val  = '0;
    sw_val = '0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 5) == 0) b_val[i] = ~b_val[i];
      end
      if ($urandom_range(0, 3) == 0) sw_val = 8'($urandom);
      button_raw  = b_val;
      switch1_raw = sw_val;
      step(1);
      chk("rnd_level", {29'd0, btn_level}, {29'd0, m_level});
      chk("rnd_press", {29'd0, btn_press}, {29'd0, m_press});
      chk("rnd_release", {29'd0, btn_release}, {29'd0, m_release});
      chk("rnd_switch", {24'd0, switch1}, {24'd0, m_sw});
      chk("rnd_overlap", {29'd0, btn_press & btn_release}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
